// File: rtl/usb_ddr3_pkg.sv
// usb_ddr3_pkg: shared FSM state encoding and source-id constants for the USB->DDR3 stream arbiter
package usb_ddr3_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DRAIN} state_t;
  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;
endpackage

// File: rtl/usb_ddr3_stream_arbiter_skid.sv
// axis_skid: 2-entry register slice, registered output, full throughput, in_ready = not full
// Ports: clock/reset; in_valid/in_ready/in_data (upstream); out_valid/out_ready/out_data (downstream)
module axis_skid #(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic             sk_valid;
  logic [WIDTH-1:0] sk_data;
  assign in_ready = !sk_valid;
  // The skid entry only fills when the output is stalled, so sk_valid means both entries are held.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sk_valid  <= 1'b0;
      sk_data   <= '0;
    end else if (sk_valid) begin
      if (out_ready) begin
        out_data <= sk_data;
        sk_valid <= 1'b0;
      end
    end else if (in_valid) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        sk_valid <= 1'b1;
        sk_data  <= in_data;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/usb_ddr3_stream_arbiter.sv
// usb_ddr3_stream_arbiter: packet-granular round-robin merge of two USB byte streams onto one DDR3 write stream
// Ports: clock/reset (sync, active-high); s0_*/s1_* byte sources; m_* merged output with source id on m_tuser;
//   busy_o = grant held; trunc_o = one-cycle pulse on truncation.
// Build option: define ARB_STATS_EN to add saturating pkts0_o, pkts1_o and trunc_cnt_o counters.
module usb_ddr3_stream_arbiter #(
  parameter int MAX_LEN = 512,
  parameter int CBITS   = 10,
  parameter bit PRIO_S0 = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        s0_tvalid,
  output logic        s0_tready,
  input  logic        s0_tlast,
  input  logic [7:0]  s0_tdata,
  input  logic        s1_tvalid,
  output logic        s1_tready,
  input  logic        s1_tlast,
  input  logic [7:0]  s1_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic [7:0]  m_tdata,
  output logic        m_tuser,
  output logic        busy_o,
  output logic        trunc_o
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] pkts0_o,
  output logic [15:0] pkts1_o,
  output logic [15:0] trunc_cnt_o
`endif
);
  import usb_ddr3_pkg::*;
  state_t           state, state_n;
  logic [CBITS-1:0] cnt;
  logic             rr, gnt, winner, sel_valid, sel_last, g_ready, buf_ready, acc, at_max, trunc_n;
  logic [7:0]       sel_data;
  assign sel_valid = gnt ? s1_tvalid : s0_tvalid;
  assign sel_last  = gnt ? s1_tlast : s0_tlast;
  assign sel_data  = gnt ? s1_tdata : s0_tdata;
  assign at_max    = cnt == CBITS'(MAX_LEN - 1);
  assign g_ready   = state == ST_DRAIN || (state == ST_PASS && buf_ready);
  assign s0_tready = g_ready && gnt == SRC0;
  assign s1_tready = g_ready && gnt == SRC1;
  assign acc       = sel_valid && g_ready;
  assign winner    = (s0_tvalid && s1_tvalid) ? rr : (s1_tvalid ? SRC1 : SRC0);
  assign busy_o    = state != ST_IDLE;
  always_comb begin
    state_n = state;
    trunc_n = 1'b0;
    state_n = state == ST_IDLE ? ((s0_tvalid || s1_tvalid) ? ST_PASS : ST_IDLE)
            : state == ST_PASS ? (acc ? (sel_last ? ST_IDLE : (at_max ? ST_DRAIN : ST_PASS)) : ST_PASS)
            : (acc && sel_last) ? ST_IDLE : ST_DRAIN;
    trunc_n = state == ST_PASS && acc && !sel_last && at_max;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rr      <= PRIO_S0 ? SRC0 : SRC1;
      gnt     <= SRC0;
      trunc_o <= 1'b0;
    end else begin
      state   <= state_n;
      trunc_o <= trunc_n;
      if (state == ST_IDLE && (s0_tvalid || s1_tvalid)) begin
        gnt <= winner;
        rr  <= ~winner;
      end
      if (state == ST_PASS && acc) cnt <= (sel_last || at_max) ? '0 : cnt + 1'b1;
    end
  end
  // Byte MAX_LEN of an over-long packet is written with a forced tlast.
  axis_skid #(.WIDTH(10)) u_skid (
    .clock    (clock),
    .reset    (reset),
    .in_valid (state == ST_PASS && sel_valid),
    .in_ready (buf_ready),
    .in_data  ({sel_last || at_max, gnt, sel_data}),
    .out_valid(m_tvalid),
    .out_ready(m_tready),
    .out_data ({m_tlast, m_tuser, m_tdata})
  );
`ifdef ARB_STATS_EN
  logic done;
  assign done = acc && sel_last;
  always_ff @(posedge clock) begin
    if (reset) begin
      pkts0_o     <= '0;
      pkts1_o     <= '0;
      trunc_cnt_o <= '0;
    end else begin
      if (done && gnt == SRC0 && pkts0_o != 16'hFFFF) pkts0_o <= pkts0_o + 16'd1;
      if (done && gnt == SRC1 && pkts1_o != 16'hFFFF) pkts1_o <= pkts1_o + 16'd1;
      if (trunc_n && trunc_cnt_o != 16'hFFFF) trunc_cnt_o <= trunc_cnt_o + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_usb_ddr3_stream_arbiter.sv
// tb_usb_ddr3_stream_arbiter: table-driven packet tests plus contention and reset sequences, scoreboard-checked
module tb_usb_ddr3_stream_arbiter;
  localparam int ML = 512;
  logic clock = 1'b0, reset = 1'b1;
  logic s0_tvalid = 1'b0, s0_tlast = 1'b0, s1_tvalid = 1'b0, s1_tlast = 1'b0, m_tready = 1'b1;
  logic [7:0] s0_tdata = '0, s1_tdata = '0;
  logic s0_tready, s1_tready, m_tvalid, m_tlast, m_tuser, busy_o, trunc_o;
  logic [7:0] m_tdata;
`ifdef ARB_STATS_EN
  logic [15:0] pkts0_o, pkts1_o, trunc_cnt_o;
`endif
  always #5 clock = ~clock;
  usb_ddr3_stream_arbiter #(.MAX_LEN(ML), .CBITS(10), .PRIO_S0(1'b1)) dut (
    .clock(clock), .reset(reset),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tlast(s0_tlast), .s0_tdata(s0_tdata),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tlast(s1_tlast), .s1_tdata(s1_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata), .m_tuser(m_tuser),
    .busy_o(busy_o), .trunc_o(trunc_o)
`ifdef ARB_STATS_EN
    , .pkts0_o(pkts0_o), .pkts1_o(pkts1_o), .trunc_cnt_o(trunc_cnt_o)
`endif
  );
  int checks = 0, passed = 0;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask
  typedef struct {int src; int len; int base; int step; bit rnd; int exp_out; int exp_trunc;} row_t;
  row_t rows[5];
  logic [9:0] sb[$];
  int order[$];
  int idx[2];
  int out_cnt = 0, trunc_seen = 0;
  bit prev_stall = 0, in_pkt = 0, rnd_rdy = 0;
  logic [9:0] prev_out;
  logic cur_user;
  task automatic model_accept(input int s, input logic l, input logic [7:0] d);
    if (idx[s] < ML) sb.push_back({l || idx[s] == ML - 1, 1'(s), d});
    idx[s] = l ? 0 : idx[s] + 1;
  endtask
  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
      idx[0] = 0;
      idx[1] = 0;
      prev_stall = 0;
      in_pkt = 0;
    end else begin
      if (prev_stall) chk("stall_hold", {m_tvalid, m_tlast, m_tuser, m_tdata}, {1'b1, prev_out});
      if (s0_tready || s1_tready) chk("single_ready", int'(s0_tready && s1_tready), 0);
      if (m_tvalid && m_tready) begin
        out_cnt++;
        chk("sb_nonempty", int'(sb.size() > 0), 1);
        if (sb.size() > 0) chk("out_byte", {m_tlast, m_tuser, m_tdata}, sb.pop_front());
        if (in_pkt) chk("no_interleave", m_tuser, cur_user);
        in_pkt = !m_tlast;
        cur_user = m_tuser;
        if (m_tlast) order.push_back(int'(m_tuser));
      end
      if (trunc_o) trunc_seen++;
      if (s0_tvalid && s0_tready) model_accept(0, s0_tlast, s0_tdata);
      if (s1_tvalid && s1_tready) model_accept(1, s1_tlast, s1_tdata);
      prev_stall = m_tvalid && !m_tready;
      prev_out = {m_tlast, m_tuser, m_tdata};
    end
  end
  initial forever begin
    @(posedge clock);
    #1;
    m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  task automatic send(input int s, input int len, input int base, input int step);
    logic [7:0] d;
    logic l;
    int t;
    bit acc;
    for (int i = 0; i < len; i++) begin
      d = 8'(base + i * step);
      l = i == len - 1;
      if (s == 0) begin s0_tvalid = 1'b1; s0_tdata = d; s0_tlast = l; end
      else begin s1_tvalid = 1'b1; s1_tdata = d; s1_tlast = l; end
      t = 0;
      acc = 0;
      while (!acc && t < 5000) begin
        @(negedge clock);
        acc = (s == 0) ? s0_tready : s1_tready;
        @(posedge clock);
        #1;
        t++;
      end
      if (!acc) begin
        chk("src_accept_timeout", int'(acc), 1);
        break;
      end
    end
    if (s == 0) begin s0_tvalid = 1'b0; s0_tlast = 1'b0; end
    else begin s1_tvalid = 1'b0; s1_tlast = 1'b0; end
  endtask
  task automatic wait_drain();
    for (int t = 0; t < 3000 && sb.size() != 0; t++) @(posedge clock);
    repeat (3) @(posedge clock);
    #1;
    chk("drain", sb.size(), 0);
  endtask
  task automatic chk_reset();
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tuser", m_tuser, 0);
    chk("rst_s_tready", {s0_tready, s1_tready}, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_trunc", trunc_o, 0);
`ifdef ARB_STATS_EN
    chk("rst_stats", {pkts0_o, pkts1_o, trunc_cnt_o} == '0, 1);
`endif
  endtask
  initial begin
    rows[0] = '{0, 4, 'h11, 'h11, 1'b0, 4, 0};
    rows[1] = '{1, 600, 0, 1, 1'b0, 512, 1};
    rows[2] = '{0, 512, 7, 1, 1'b0, 512, 0};
    rows[3] = '{1, 64, 'h40, 3, 1'b1, 64, 0};
    rows[4] = '{0, 513, 9, 5, 1'b0, 512, 1};
    repeat (3) @(posedge clock);
    #1;
    chk_reset();
    reset = 1'b0;
    @(posedge clock);
    #1;
    fork
      send(0, 5, 'hA0, 1);
      send(1, 5, 'hB0, 1);
    join
    wait_drain();
    fork
      send(0, 3, 'hC0, 1);
      send(1, 3, 'hD0, 1);
    join
    wait_drain();
    chk("rr_pkts", order.size(), 4);
    if (order.size() == 4) begin
      chk("rr_first", order[0], 0);
      chk("rr_second", order[1], 1);
      chk("rr_third", order[2], 0);
      chk("rr_fourth", order[3], 1);
    end
    foreach (rows[r]) begin
      out_cnt = 0;
      trunc_seen = 0;
      rnd_rdy = rows[r].rnd;
      send(rows[r].src, rows[r].len, rows[r].base, rows[r].step);
      chk($sformatf("row%0d_busy_after_last", r), busy_o, 0);
      wait_drain();
      rnd_rdy = 0;
      repeat (2) @(posedge clock);
      #1;
      chk($sformatf("row%0d_out_bytes", r), out_cnt, rows[r].exp_out);
      chk($sformatf("row%0d_trunc_pulses", r), trunc_seen, rows[r].exp_trunc);
    end
    s0_tvalid = 1'b1;
    s0_tdata = 8'h5A;
    s0_tlast = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    reset = 1'b1;
    s0_tvalid = 1'b0;
    @(posedge clock);
    #1;
    chk_reset();
    reset = 1'b0;
    out_cnt = 0;
    send(1, 8, 'h30, 3);
    wait_drain();
    chk("post_reset_bytes", out_cnt, 8);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout: still running at 1000000 ns, required to finish before");
    $fatal(1);
  end
endmodule
